somador_loadstore_seq: RTL and testbench

Load/store sequencer directly upstream of the two's-complement adder control unit and datapath. It reads operand pairs A[i], B[i] from a synchronous word memory and presents them to the adder. It starts the adder, waits for its done, then writes the result to R[i], repeating for a programmed count. It also clears the adder between operations, because the adder stays in its done state until it is reset.

---
 rtl/somador_pkg.sv | 8 +
 rtl/somador_loadstore_seq_if.sv | 26 ++
 rtl/seq_addr_gen.sv | 36 +++
 rtl/somador_loadstore_seq.sv | 97 +++++++++
 tb/tb_somador_loadstore_seq.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/somador_pkg.sv
// somador_pkg: shared state encoding and default widths for the load/store sequencer
package somador_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  typedef enum logic [3:0] {
    INIT, IDLE, RD_A, RD_B, LAT_B, START, WAIT, WRITE, CLR, FIN
  } state_t;
endpackage

// File: rtl/somador_loadstore_seq_if.sv
// somador_loadstore_seq_if: control, memory and adder signals of the sequencer
interface somador_loadstore_seq_if
  import somador_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic go;
  logic [ADDR_W-1:0] base_a, base_b, base_r, count;
  logic mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_rd_data, mem_wr_data;
  logic [DATA_W-1:0] op_a, op_b, add_result;
  logic add_start, add_clr, add_done;
  logic busy, done, err;
  modport master (
    output go, base_a, base_b, base_r, count, mem_rd_data, add_done, add_result,
    input mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input op_a, op_b, add_start, add_clr, busy, done, err
  );
  modport slave (
    input go, base_a, base_b, base_r, count, mem_rd_data, add_done, add_result,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output op_a, op_b, add_start, add_clr, busy, done, err
  );
endinterface

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: latched vector bases plus running index; addresses wrap modulo 2^ADDR_W
module seq_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic              sel_b_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_r_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);
  logic [ADDR_W-1:0] base_a_q, base_b_q, base_r_q, idx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      idx_q    <= '0;
    end else if (load_i) begin
      base_a_q <= base_a_i;
      base_b_q <= base_b_i;
      base_r_q <= base_r_i;
      idx_q    <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + ADDR_W'(1);
    end
  end
  assign idx_o     = idx_q;
  assign rd_addr_o = (sel_b_i ? base_b_q : base_a_q) + idx_q;
  assign wr_addr_o = base_r_q + idx_q;
endmodule

// File: rtl/somador_loadstore_seq.sv
// somador_loadstore_seq: feeds operand pairs from memory to the adder and stores results.
// Optional SEQ_TIMEOUT_EN bounds the wait for add_done and raises a sticky err.
module somador_loadstore_seq
  import somador_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 32
) (
  input logic clk,
  input logic RESET,
  somador_loadstore_seq_if.slave bus
);
  state_t state_q;
  logic [ADDR_W-1:0] cnt_q, idx;
  logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
  logic err_q;
`ifdef SEQ_TIMEOUT_EN
  localparam int WC_W = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  logic [WC_W-1:0] wcnt_q;
`endif
  seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst_n    (RESET),
    .load_i   (state_q == IDLE && bus.go),
    .inc_i    (state_q == CLR),
    .sel_b_i  (state_q == RD_B),
    .base_a_i (bus.base_a),
    .base_b_i (bus.base_b),
    .base_r_i (bus.base_r),
    .idx_o    (idx),
    .rd_addr_o(bus.mem_rd_addr),
    .wr_addr_o(bus.mem_wr_addr)
  );
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= INIT;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        INIT:  state_q <= IDLE;
        IDLE: if (bus.go) begin
          cnt_q   <= bus.count;
          err_q   <= 1'b0;
          state_q <= bus.count == '0 ? FIN : RD_A;
        end
        RD_A:  state_q <= RD_B;
        RD_B: begin
          op_a_q  <= bus.mem_rd_data;
          state_q <= LAT_B;
        end
        LAT_B: begin
          op_b_q  <= bus.mem_rd_data;
          state_q <= START;
        end
        START: begin
`ifdef SEQ_TIMEOUT_EN
          wcnt_q  <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: if (bus.add_done) begin
          res_q   <= bus.add_result;
          state_q <= WRITE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
          err_q   <= 1'b1;
          state_q <= CLR;
        end else wcnt_q <= wcnt_q + WC_W'(1);
`endif
        WRITE: state_q <= CLR;
        // a timed-out batch abandons its remaining operations
        CLR:   state_q <= (err_q || idx + ADDR_W'(1) == cnt_q) ? FIN : RD_A;
        FIN:   state_q <= IDLE;
        default: state_q <= INIT;
      endcase
    end
  end
  assign bus.mem_rd_en   = state_q == RD_A || state_q == RD_B;
  assign bus.mem_wr_en   = state_q == WRITE;
  assign bus.mem_wr_data = res_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.add_start   = state_q == START;
  assign bus.add_clr     = state_q == INIT || state_q == CLR;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == FIN;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_somador_loadstore_seq.sv
// tb_somador_loadstore_seq: memory and adder models around the sequencer, checked
// against a vector-level model of R[i] = A[i] + B[i]; timeout case under SEQ_TIMEOUT_EN.
module tb_somador_loadstore_seq;
  logic clk = 1'b0;
  logic RESET = 1'b0;
  always #5 clk = ~clk;
  somador_loadstore_seq_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  somador_loadstore_seq #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (bus)
  );
  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic tb_wr = 1'b0;
  logic [3:0] tb_waddr = '0;
  logic [7:0] tb_wdata = '0;
  int add_lat = 4;
  bit adder_dead = 1'b0;
  int acnt = -1;
  int n_start = 0, n_clr = 0, n_done = 0, n_wr = 0;
  logic [3:0] rd_log [$];
  int vectors = 0, errs = 0;
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    else if (tb_wr) mem[tb_waddr] <= tb_wdata;
  end
  always @(posedge clk) begin
    if (bus.add_clr) begin
      bus.add_done <= 1'b0;
      acnt <= -1;
    end else if (bus.add_start) acnt <= add_lat;
    else if (acnt > 0) acnt <= acnt - 1;
    else if (acnt == 0 && !adder_dead) begin
      bus.add_done   <= 1'b1;
      bus.add_result <= bus.op_a + bus.op_b;
      acnt <= -1;
    end
  end
  always @(negedge clk) begin
    n_start += int'(bus.add_start);
    n_clr   += int'(bus.add_clr);
    n_done  += int'(bus.done);
    n_wr    += int'(bus.mem_wr_en);
    if (bus.mem_rd_en) rd_log.push_back(bus.mem_rd_addr);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load_mem();
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      tb_wr = 1'b1; tb_waddr = 4'(k); tb_wdata = exp_mem[k];
    end
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask
  task automatic model_batch(input logic [3:0] ba, bb, br, cnt);
    for (int i = 0; i < int'(cnt); i++)
      exp_mem[4'(int'(br) + i)] = exp_mem[4'(int'(ba) + i)] + exp_mem[4'(int'(bb) + i)];
  endtask
  task automatic start_batch(input logic [3:0] ba, bb, br, cnt);
    @(posedge clk); #1;
    bus.base_a = ba; bus.base_b = bb; bus.base_r = br; bus.count = cnt; bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 2000 && bus.done !== 1'b1; i++) @(negedge clk);
    chk("done_seen", 32'(bus.done), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic chk_mem(input string tag);
    for (int k = 0; k < 16; k++) chk(tag, 32'(mem[k]), 32'(exp_mem[k]));
  endtask
  initial begin
    int s0, c0, d0, w0, r0;
    logic [3:0] ba, bb, br, cnt;
    bus.go = 1'b0; bus.base_a = '0; bus.base_b = '0; bus.base_r = '0; bus.count = '0;
    for (int k = 0; k < 16; k++) exp_mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_clr", 32'(bus.add_clr), 32'd1);
    chk("rst_strobes", 32'({bus.mem_rd_en, bus.mem_wr_en, bus.add_start, bus.done}), 32'd0);
    chk("rst_ops", 32'({bus.op_a, bus.op_b, 7'd0, bus.err}), 32'd0);
    @(posedge clk); #1;
    RESET = 1'b1;
    @(negedge clk);
    chk("init_clr", 32'(bus.add_clr), 32'd1);
    @(negedge clk);
    chk("idle_clr", 32'(bus.add_clr), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_strobes", 32'({bus.mem_rd_en, bus.mem_wr_en, bus.add_start, bus.done}), 32'd0);
    exp_mem[0] = 8'd5; exp_mem[4] = 8'hFD;
    load_mem();
    s0 = n_start; c0 = n_clr; d0 = n_done;
    model_batch(4'd0, 4'd4, 4'd8, 4'd1);
    start_batch(4'd0, 4'd4, 4'd8, 4'd1);
    wait_done();
    chk("single_r", 32'(mem[8]), 32'h02);
    chk("single_start", 32'(n_start - s0), 32'd1);
    chk("single_clr", 32'(n_clr - c0), 32'd1);
    chk("single_done", 32'(n_done - d0), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      exp_mem[k] = 8'(k + 1);
      exp_mem[4 + k] = 8'(10 * (k + 1));
    end
    load_mem();
    add_lat = 2;
    s0 = n_start; c0 = n_clr; d0 = n_done; w0 = n_wr;
    model_batch(4'd0, 4'd4, 4'd8, 4'd3);
    start_batch(4'd0, 4'd4, 4'd8, 4'd3);
    for (int i = 0; i < 2000 && bus.done !== 1'b1; i++) @(negedge clk);
    chk("batch_wr_before_done", 32'(n_wr - w0), 32'd3);
    wait_done();
    chk("batch_r0", 32'(mem[8]), 32'd11);
    chk("batch_r1", 32'(mem[9]), 32'd22);
    chk("batch_r2", 32'(mem[10]), 32'd33);
    chk("batch_start", 32'(n_start - s0), 32'd3);
    chk("batch_clr", 32'(n_clr - c0), 32'd3);
    chk("batch_done", 32'(n_done - d0), 32'd1);
    s0 = n_start; c0 = n_clr; w0 = n_wr; r0 = rd_log.size();
    start_batch(4'd3, 4'd5, 4'd7, 4'd0);
    @(negedge clk);
    chk("cnt0_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("cnt0_done_end", 32'(bus.done), 32'd0);
    chk("cnt0_busy", 32'(bus.busy), 32'd0);
    chk("cnt0_strobes", 32'((n_start - s0) + (n_clr - c0) + (n_wr - w0) + (rd_log.size() - r0)), 32'd0);
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'($urandom);
    load_mem();
    add_lat = 3;
    s0 = n_start; d0 = n_done; r0 = rd_log.size();
    model_batch(4'd14, 4'd4, 4'd8, 4'd3);
    start_batch(4'd14, 4'd4, 4'd8, 4'd3);
    repeat (5) @(negedge clk);
    bus.go = 1'b1; bus.base_a = 4'd1; bus.count = 4'd5;
    @(negedge clk);
    bus.go = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("wrap_rd0", 32'(rd_log[r0]), 32'd14);
    chk("wrap_rd1", 32'(rd_log[r0 + 2]), 32'd15);
    chk("wrap_rd2", 32'(rd_log[r0 + 4]), 32'd0);
    chk("wrap_rdb2", 32'(rd_log[r0 + 5]), 32'd6);
    chk("wrap_start", 32'(n_start - s0), 32'd3);
    chk("wrap_done", 32'(n_done - d0), 32'd1);
    chk("wrap_busy", 32'(bus.busy), 32'd0);
    chk_mem("wrap_mem");
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 16; k++) exp_mem[k] = 8'($urandom);
      load_mem();
      add_lat = int'($urandom_range(0, 5));
      ba = 4'($urandom); bb = 4'($urandom); br = 4'($urandom); cnt = 4'($urandom_range(0, 9));
      d0 = n_done;
      model_batch(ba, bb, br, cnt);
      start_batch(ba, bb, br, cnt);
      wait_done();
      chk("rand_done", 32'(n_done - d0), 32'd1);
      chk("rand_err", 32'(bus.err), 32'd0);
      chk_mem("rand_mem");
    end
`ifdef SEQ_TIMEOUT_EN
    adder_dead = 1'b1;
    s0 = n_start; c0 = n_clr; d0 = n_done; w0 = n_wr;
    start_batch(4'd0, 4'd4, 4'd8, 4'd3);
    wait_done();
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_wr", 32'(n_wr - w0), 32'd0);
    chk("to_start", 32'(n_start - s0), 32'd1);
    chk("to_clr", 32'(n_clr - c0), 32'd1);
    chk("to_done", 32'(n_done - d0), 32'd1);
    chk_mem("to_mem");
    adder_dead = 1'b0;
    start_batch(4'd0, 4'd4, 4'd8, 4'd0);
    @(negedge clk);
    chk("to_err_clr", 32'(bus.err), 32'd0);
    repeat (2) @(negedge clk);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
